// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory port.
// The arbiter connects through the slave modport; requesters and memory use the master modport.
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              req0_i;
  logic              req1_i;
  logic              write0_i;
  logic              write1_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata0_i;
  logic [DATA_W-1:0] wdata1_i;
  logic              ack0_o;
  logic              ack1_o;
  logic [DATA_W-1:0] rdata_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;

  modport slave (
    input  req0_i, req1_i, write0_i, write1_i,
    input  addr0_i, addr1_i, wdata0_i, wdata1_i,
    input  mem_ack_i, mem_data_i,
    output ack0_o, ack1_o, rdata_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output req0_i, req1_i, write0_i, write1_i,
    output addr0_i, addr1_i, wdata0_i, wdata1_i,
    output mem_ack_i, mem_data_i,
    input  ack0_o, ack1_o, rdata_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the I-cache and D-cache refill paths.
// The winning request is latched at grant and held toward memory until mem_ack_i, then acked for one cycle.
module dm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input logic         clk_i,
  input logic         rst_i,
  dm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              winner;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    winner       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0_i || bus.req1_i) begin
          // Under contention the port that did not win last time goes first.
          winner       = (bus.req0_i && bus.req1_i) ? ~last_grant_q : bus.req1_i;
          grant_d      = winner;
          mem_write_d  = winner ? bus.write1_i : bus.write0_i;
          mem_addr_d   = winner ? bus.addr1_i  : bus.addr0_i;
          mem_data_d   = winner ? bus.wdata1_i : bus.wdata0_i;
          mem_enable_d = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ack_i) begin
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
          ack0_d       = ~grant_q;
          ack1_d       = grant_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  assign bus.ack0_o       = ack0_q;
  assign bus.ack1_o       = ack1_q;
  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
  assign bus.rdata_o      = bus.mem_data_i;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a behavioural latency-10 memory plus a scoreboard of expected acks
// (port, data, cycle) checked whenever the arbiter pulses an acknowledge.
module tb_dm_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 256;
  localparam int LAT    = 10;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stray_ack = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mem_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  localparam logic [DATA_W-1:0] PAT_A5   = {32{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_1234 = {16{16'h1234}};
  localparam logic [DATA_W-1:0] PAT_BAD  = {8{32'h0BAD_F00D}};
  localparam logic [DATA_W-1:0] PAT_DEAD = {8{32'hDEAD_BEEF}};

  dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Memory acks in the tenth cycle of mem_enable_o and updates its data register on that same cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_cnt        = 0;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
    end else begin
      bus.mem_ack_i = 1'b0;
      if (bus.mem_enable_o) begin
        mem_cnt++;
        if (mem_cnt == LAT) begin
          bus.mem_ack_i = 1'b1;
          if (bus.mem_write_o) begin
            mem[bus.mem_addr_o] = bus.mem_data_o;
            bus.mem_data_i      = bus.mem_data_o;
          end else begin
            bus.mem_data_i = mem.exists(bus.mem_addr_o) ? mem[bus.mem_addr_o] : '0;
          end
        end
      end else begin
        mem_cnt = 0;
      end
      if (stray_ack) bus.mem_ack_i = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && (bus.ack0_o || bus.ack1_o)) begin
      check_output("ack_both", DATA_W'(bus.ack0_o & bus.ack1_o), '0);
      if (sb.size() == 0) begin
        check_output("ack_pending", DATA_W'(sb.size()), DATA_W'(1));
      end else begin
        mon_e = sb.pop_front();
        check_output("ack_port", DATA_W'(bus.ack1_o), DATA_W'(mon_e.port));
        check_output("ack_rdata", bus.rdata_o, mon_e.data);
        check_output("ack_cycle", DATA_W'(cyc), DATA_W'(mon_e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata);
    if (port == 0) begin
      bus.req0_i = 1'b1; bus.write0_i = wr; bus.addr0_i = addr; bus.wdata0_i = wdata;
    end else begin
      bus.req1_i = 1'b1; bus.write1_i = wr; bus.addr1_i = addr; bus.wdata1_i = wdata;
    end
  endtask

  task automatic set_req(input int port, input logic val);
    if (port == 0) bus.req0_i = val;
    else           bus.req1_i = val;
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_en"},   DATA_W'(bus.mem_enable_o), '0);
    check_output({tag, "_wr"},   DATA_W'(bus.mem_write_o), '0);
    check_output({tag, "_addr"}, DATA_W'(bus.mem_addr_o), '0);
    check_output({tag, "_data"}, bus.mem_data_o, '0);
    check_output({tag, "_ack0"}, DATA_W'(bus.ack0_o), '0);
    check_output({tag, "_ack1"}, DATA_W'(bus.ack1_o), '0);
  endtask

  // One transaction from an idle arbiter: enable window, latched fields, optional mid-flight edits.
  task automatic apply_stimulus(input int port, input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_data,
                                input int drop_at, input logic chg_addr,
                                input logic [ADDR_W-1:0] new_addr);
    exp_t e;
    drive(port, wr, addr, wdata);
    e.port = port; e.data = exp_data; e.cyc = cyc + LAT + 1;
    sb.push_back(e);
    for (int k = 0; k <= LAT + 1; k++) begin
      if (k == drop_at) set_req(port, 1'b0);
      if (chg_addr && k == 3) begin
        if (port == 0) bus.addr0_i = new_addr;
        else           bus.addr1_i = new_addr;
      end
      @(negedge clk);
      check_output($sformatf("p%0d_en_c%0d", port, k), DATA_W'(bus.mem_enable_o),
                   DATA_W'(k >= 1 && k <= LAT));
      if (k == 1 || k == LAT) begin
        check_output($sformatf("p%0d_addr_c%0d", port, k), DATA_W'(bus.mem_addr_o), DATA_W'(addr));
        check_output($sformatf("p%0d_wr_c%0d", port, k), DATA_W'(bus.mem_write_o), DATA_W'(wr));
        if (wr) check_output($sformatf("p%0d_wdata_c%0d", port, k), bus.mem_data_o, wdata);
      end
      tick();
    end
    set_req(port, 1'b0);
  endtask

  // Both ports read in the same cycle; port 0 is expected first, port 1 right after it.
  task automatic apply_contention(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                  input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    exp_t e;
    drive(0, 1'b0, a0, '0);
    drive(1, 1'b0, a1, '0);
    e.port = 0; e.data = d0; e.cyc = cyc + LAT + 1;
    sb.push_back(e);
    e.port = 1; e.data = d1; e.cyc = cyc + 2 * LAT + 3;
    sb.push_back(e);
    for (int k = 0; k <= 2 * LAT + 3; k++) begin
      if (k == LAT + 2) set_req(0, 1'b0);
      @(negedge clk);
      check_output($sformatf("ct_en_c%0d", k), DATA_W'(bus.mem_enable_o),
                   DATA_W'((k >= 1 && k <= LAT) || (k >= LAT + 3 && k <= 2 * LAT + 2)));
      if (k == 1)       check_output("ct_addr_first", DATA_W'(bus.mem_addr_o), DATA_W'(a0));
      if (k == LAT + 3) check_output("ct_addr_second", DATA_W'(bus.mem_addr_o), DATA_W'(a1));
      tick();
    end
    set_req(1, 1'b0);
  endtask

  initial begin
    bus.req0_i = 1'b0; bus.write0_i = 1'b0; bus.addr0_i = '0; bus.wdata0_i = '0;
    bus.req1_i = 1'b0; bus.write1_i = 1'b0; bus.addr1_i = '0; bus.wdata1_i = '0;
    mem[32'h40] = PAT_A5;
    mem[32'hC0] = PAT_BAD;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    $display("[TB] single read, port 0");
    apply_stimulus(0, 1'b0, 32'h40, '0, PAT_A5, -1, 1'b0, '0);

    $display("[TB] write then read, port 1");
    apply_stimulus(1, 1'b1, 32'h80, PAT_1234, PAT_1234, -1, 1'b0, '0);
    apply_stimulus(1, 1'b0, 32'h80, '0, PAT_1234, -1, 1'b0, '0);

    $display("[TB] address change after grant");
    apply_stimulus(1, 1'b0, 32'h80, '0, PAT_1234, -1, 1'b1, 32'hC0);

    $display("[TB] contention from reset");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    apply_contention(32'h40, 32'hC0, PAT_A5, PAT_BAD);
    apply_contention(32'hC0, 32'h40, PAT_BAD, PAT_A5);

    $display("[TB] stray mem ack in idle, then req dropped mid-transaction");
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    @(negedge clk);
    check_output("stray_en", DATA_W'(bus.mem_enable_o), '0);
    check_output("stray_ack0", DATA_W'(bus.ack0_o), '0);
    tick();
    apply_stimulus(0, 1'b0, 32'h40, '0, PAT_A5, 4, 1'b0, '0);

    $display("[TB] reset during a write");
    drive(1, 1'b1, 32'h100, PAT_DEAD);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    tick();
    tick();
    check_output("midrst_no_write", DATA_W'(mem.exists(32'h100)), '0);
    rst_n = 1'b1;
    apply_stimulus(1, 1'b1, 32'h100, PAT_DEAD, PAT_DEAD, -1, 1'b0, '0);

    repeat (4) tick();
    check_output("sb_drain", DATA_W'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
